// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bundle: per-requester valid/addr/data with one-hot ready.
// Requesters drive the master side, the write-port arbiter takes the slave side.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback units.
// Define REGFILE_ARB_SCOREBOARD_EN to build the busy-register scoreboard.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   regfile_write_arbiter_if.slave req,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_write_address,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic [ADDR_W-1:0] query_addr_1,
   input  logic [ADDR_W-1:0] query_addr_2,
   output logic              query_busy_1,
   output logic              query_busy_2
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [PTR_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               gnt;
   logic [NUM_REQ-1:0] ready;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;

   logic               we_q;
   logic               we_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  data_d;

   function automatic logic [PTR_W-1:0] rr_idx(
      input logic [PTR_W-1:0] base,
      input int               off
   );
      int s;
      s = off + int'(base);
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[PTR_W-1:0];
   endfunction

   // Scan from the highest offset down so the entry nearest ptr wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = ptr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req.req_valid[rr_idx(ptr_q, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_idx(ptr_q, k);
         end
      end
      gnt = gnt_any & reset_n;
   end

   always_comb begin
      ready = '0;
      if (gnt) ready[gnt_idx] = 1'b1;
   end

   assign req.req_ready = ready;

   always_comb begin
      win_addr = req.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      win_data = req.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
   end

   always_comb begin
      ptr_d  = ptr_q;
      addr_d = addr_q;
      data_d = data_q;
      we_d   = 1'b0;
      if (gnt) begin
         ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         addr_d = win_addr;
         data_d = win_data;
         // x0 transfers are accepted but never reach the register file
         we_d   = (win_addr != '0);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign rf_write_enable  = we_q;
   assign rf_write_address = addr_q;
   assign rf_write_data    = data_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN

   localparam int NREGS = 1 << ADDR_W;

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             rsv_set;

   assign rsv_ready = (rsv_addr == '0) | ~busy_q[rsv_addr];
   assign rsv_set   = rsv_valid & rsv_ready & (rsv_addr != '0);

   // Clear first so a same-edge reservation of the written register wins.
   always_comb begin
      busy_d = busy_q;
      if (we_q) busy_d[addr_q] = 1'b0;
      if (rsv_set) busy_d[rsv_addr] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // The register file is write-first, so a register written now reads ready.
   assign query_busy_1 = (query_addr_1 != '0) & busy_q[query_addr_1]
                       & ~(we_q & (addr_q == query_addr_1));
   assign query_busy_2 = (query_addr_2 != '0) & busy_q[query_addr_2]
                       & ~(we_q & (addr_q == query_addr_2));

`else

   logic unused_sb;

   assign unused_sb    = ^{rsv_valid, rsv_addr, query_addr_1, query_addr_2};
   assign rsv_ready    = 1'b1;
   assign query_busy_1 = 1'b0;
   assign query_busy_2 = 1'b0;

`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, round-robin, x0, scoreboard.
// Scoreboard steps follow whichever build of REGFILE_ARB_SCOREBOARD_EN is used.
module tb_regfile_write_arbiter;

   localparam int NUM_REQ = 3;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;

   logic              clock;
   logic              reset_n;
   logic              rf_write_enable;
   logic [ADDR_W-1:0] rf_write_address;
   logic [DATA_W-1:0] rf_write_data;
   logic              rsv_valid;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ready;
   logic [ADDR_W-1:0] query_addr_1;
   logic [ADDR_W-1:0] query_addr_2;
   logic              query_busy_1;
   logic              query_busy_2;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter_if #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) rif ();

   regfile_write_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .req              (rif),
      .rf_write_enable  (rf_write_enable),
      .rf_write_address (rf_write_address),
      .rf_write_data    (rf_write_data),
      .rsv_valid        (rsv_valid),
      .rsv_addr         (rsv_addr),
      .rsv_ready        (rsv_ready),
      .query_addr_1     (query_addr_1),
      .query_addr_2     (query_addr_2),
      .query_busy_1     (query_busy_1),
      .query_busy_2     (query_busy_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   int          exp_g [4] = '{0, 1, 2, 0};
   logic [4:0]  exp_a [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
   logic [31:0] exp_d [4] = '{32'hA, 32'hB, 32'hC, 32'hA};

   initial begin
      reset_n       = 1'b0;
      rif.req_valid = 3'b111;
      rif.req_addr  = {5'd3, 5'd2, 5'd1};
      rif.req_data  = {32'hC, 32'hB, 32'hA};
      rsv_valid     = 1'b0;
      rsv_addr      = '0;
      query_addr_1  = 5'd7;
      query_addr_2  = '0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_ready", rif.req_ready, 3'b000);
      check("rst_we", rf_write_enable, 1'b0);
      check("rst_addr", rf_write_address, 5'd0);
      check("rst_data", rf_write_data, 32'h0);
      check("rst_qb1", query_busy_1, 1'b0);
      check("rst_qb2", query_busy_2, 1'b0);

      reset_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rr_ready", rif.req_ready, 32'(1) << exp_g[i]);
         tick();
         check("rr_we", rf_write_enable, 1'b1);
         check("rr_addr", rf_write_address, exp_a[i]);
         check("rr_data", rf_write_data, exp_d[i]);
      end

      // ptr is now 1; only requester 0 asks
      rif.req_valid = 3'b001;
      rif.req_addr  = {5'd3, 5'd2, 5'd5};
      rif.req_data  = {32'hC, 32'hB, 32'h1234};
      #1;
      check("sparse_ready", rif.req_ready, 3'b001);
      tick();
      check("sparse_we", rf_write_enable, 1'b1);
      check("sparse_addr", rf_write_address, 5'd5);
      check("sparse_data", rf_write_data, 32'h1234);

      rif.req_addr = {5'd3, 5'd2, 5'd0};
      rif.req_data = {32'hC, 32'hB, 32'hFFFF_FFFF};
      #1;
      check("x0_ready", rif.req_ready, 3'b001);
      tick();
      check("x0_we", rf_write_enable, 1'b0);
      check("x0_data", rf_write_data, 32'hFFFF_FFFF);

      rif.req_valid = 3'b000;
      #1;
      check("idle_ready", rif.req_ready, 3'b000);
      tick();
      check("idle_we", rf_write_enable, 1'b0);
      check("idle_addr", rf_write_address, 5'd0);
      check("idle_data", rf_write_data, 32'hFFFF_FFFF);

`ifdef REGFILE_ARB_SCOREBOARD_EN
      rsv_valid = 1'b1;
      rsv_addr  = 5'd7;
      #1;
      check("sb_rsv_ok", rsv_ready, 1'b1);
      check("sb_pre_busy", query_busy_1, 1'b0);
      tick();
      rsv_valid = 1'b0;
      #1;
      check("sb_busy", query_busy_1, 1'b1);
      check("sb_rsv_blk", rsv_ready, 1'b0);

      rif.req_valid = 3'b001;
      rif.req_addr  = {5'd3, 5'd2, 5'd7};
      rif.req_data  = {32'hC, 32'hB, 32'h77};
      #1;
      tick();
      rif.req_valid = 3'b000;
      #1;
      check("sb_wr_we", rf_write_enable, 1'b1);
      check("sb_wr_fwd", query_busy_1, 1'b0);
      tick();
      check("sb_clr_busy", query_busy_1, 1'b0);
      check("sb_clr_rsv", rsv_ready, 1'b1);

      rif.req_valid = 3'b001;
      #1;
      tick();
      rif.req_valid = 3'b000;
      rsv_valid     = 1'b1;
      #1;
      check("sb_same_rsv", rsv_ready, 1'b1);
      tick();
      rsv_valid = 1'b0;
      #1;
      check("sb_same_busy", query_busy_1, 1'b1);
      check("sb_q2_x0", query_busy_2, 1'b0);
`else
      rsv_valid = 1'b1;
      rsv_addr  = 5'd7;
      #1;
      check("off_rsv0", rsv_ready, 1'b1);
      check("off_qb0", query_busy_1, 1'b0);
      tick();
      rsv_valid = 1'b0;
      #1;
      check("off_rsv1", rsv_ready, 1'b1);
      check("off_qb1", query_busy_1, 1'b0);
`endif

      // A grant seen while reset is low must never reach the write port.
      rif.req_valid = 3'b001;
      rif.req_addr  = {5'd3, 5'd2, 5'd9};
      rif.req_data  = {32'hC, 32'hB, 32'h99};
      reset_n       = 1'b0;
      #1;
      check("mrst_ready", rif.req_ready, 3'b000);
      tick();
      check("mrst_we", rf_write_enable, 1'b0);
      check("mrst_addr", rf_write_address, 5'd0);
      check("mrst_qb1", query_busy_1, 1'b0);

      reset_n = 1'b1;
      #1;
      check("mrst_ptr0", rif.req_ready, 3'b001);
      tick();
      check("mrst_wr", rf_write_address, 5'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among multiple writeback requesters (e.g. ALU, load/store unit, mul/div) in the RISC-V pipeline. Grants at most one requester per cycle using round-robin arbitration. Registers the winning address and data onto the register file write port. An optional scoreboard tracks registers with an outstanding writeback so issue logic can detect RAW/WAW hazards.

## Interface

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  synchronous, active-low reset (sampled on rising edge of clock)
- req_valid  input  NUM_REQ  requester i has a writeback pending
- req_addr  input  NUM_REQ*ADDR_W  destination register of requester i (slice i = bits [i*ADDR_W +: ADDR_W])
- req_data  input  NUM_REQ*DATA_W  write data of requester i (slice i = bits [i*DATA_W +: DATA_W])
- req_ready  output  NUM_REQ  one-hot grant; transfer of requester i occurs when req_valid[i] & req_ready[i]
- rf_write_enable  output  1  to register file write_enable
- rf_write_address  output  ADDR_W  to register file write_address
- rf_write_data  output  DATA_W  to register file write_data_in
- rsv_valid  input  1  issue stage requests reservation of rsv_addr
- rsv_addr  input  ADDR_W  register to reserve
- rsv_ready  output  1  reservation accepted this cycle
- query_addr_1, query_addr_2  input  ADDR_W  source registers to check
- query_busy_1, query_busy_2  output  1  source register has outstanding writeback

## Operation

- Arbitration:
  - Round-robin priority pointer ptr (0..NUM_REQ-1). The search starts at ptr and wraps.
  - The first index with req_valid set is granted, and its req_ready bit is set (combinational, same cycle).
  - req_ready is never asserted for an index whose req_valid is low.
  - At most one req_ready bit is high per cycle.
  - On a grant to index g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Write port:
  - On the rising edge after a transfer from g: rf_write_address <= addr[g] and rf_write_data <= data[g].
  - rf_write_enable <= 1 if addr[g] != 0, otherwise 0. An x0 write is consumed and discarded.
  - With no transfer: rf_write_enable <= 0, and address and data hold their previous values.
- Scoreboard: busy[2**ADDR_W] bits.
  - rsv_ready = (rsv_addr == 0) | ~busy[rsv_addr].
  - On rsv_valid & rsv_ready & rsv_addr != 0: busy[rsv_addr] <= 1.
  - A reservation of x0 is accepted and has no effect.
  - When rf_write_enable is high, busy[rf_write_address] <= 0 at the next edge.
  - Set and clear of the same address on the same edge: set wins.
  - query_busy_k = busy[q] & ~(rf_write_enable & rf_write_address == q), for q = query_addr_k. The register file is write-first on the same edge, so a register being written this cycle reads as not busy.
  - query_busy for x0 is always 0.
- Writes with no reservation clear nothing harmful: clearing an already-clear bit is a no-op.

## Timing

- Reset (reset_n low at a rising edge):
  - ptr = 0, rf_write_enable = 0, rf_write_address = 0, rf_write_data = 0, all busy = 0.
  - req_ready is all zero while reset_n is low.
- Reset mid-operation: a registered write not yet performed is dropped, and all reservations are lost.
- Grant-to-write latency: 1 cycle. Requester data is captured at the grant edge, and the register file writes at the following edge.
- Throughput: one writeback per cycle.
- Losing requesters must hold req_valid, req_addr and req_data stable until granted.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Reservation set is visible on query_busy in the cycle after rsv_valid & rsv_ready.
- Reservation and its clearing write in the same cycle is legal; set wins.

## Configuration

- REGFILE_ARB_SCOREBOARD_EN defined: busy array, rsv_ready and query_busy logic behave as specified above.
- REGFILE_ARB_SCOREBOARD_EN undefined:
  - No busy state is instantiated.
  - rsv_ready is tied 1, and query_busy_1 and query_busy_2 are tied 0.
  - rsv_* and query_* inputs are ignored.
  - Arbitration and write port behaviour are unchanged.

## Test plan

- Reset: hold reset_n low 2 cycles with all req_valid = 3'b111 -> req_ready = 0, rf_write_enable = 0, all query_busy = 0. After release, first grant goes to index 0.
- Round-robin: req_valid = 3'b111 held with addrs 1, 2, 3 and data 0xA, 0xB, 0xC -> grants 0, 1, 2, 0. rf_write_address sequence is 1, 2, 3, 1, each one cycle after its grant.
- Sparse requests: ptr = 1, only req_valid[0] high with addr 5 and data 0x1234 -> index 0 granted immediately. Next cycle rf_write_enable = 1, address 5, data 0x1234.
- x0 write: grant with addr 0, data 0xFFFFFFFF -> req_ready pulses, and rf_write_enable stays 0 next cycle.
- Scoreboard (macro on):
  - Reserve x7 -> next cycle query_busy_1 = 1 for x7, and rsv_ready = 0 for x7.
  - Writeback to x7 -> query_busy_1 = 0 during the rf_write_enable cycle, and the bit clears at the following edge.
  - Simultaneous reserve and write of x7 -> remains busy.
- Macro off: reserve x7 then query x7 -> query_busy_1 = 0 and rsv_ready = 1 throughout.
